// File: rtl/ifu_pcgen.sv
// ifu_pcgen: instruction-fetch PC generator and fetch controller.
// Holds the fetch PC and issues one request at a time to instruction memory.
// Fetched instructions go to decode through a one-entry output register.
// Redirects from execute kill stale fetches.
module ifu_pcgen #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_e,
  input  logic [63:0] br_addr,
  input  logic        stall,
  output logic        inst_req,
  output logic [63:0] inst_addr,
  input  logic        inst_gnt,
  input  logic        inst_rvalid,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_FULL = 2'd3
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_req_pc;
  logic        r_drop;
  logic        r_if_valid;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_inst;

  logic [63:0] w_fetch_addr;
  logic [63:0] w_br_tgt;

  assign w_fetch_addr = {r_pc[63:2], 2'b00};
  assign w_br_tgt     = {br_addr[63:2], 2'b00};

  // Outputs come only from registers or the state decode, never from inputs.
  assign inst_req  = (r_state == S_REQ);
  assign inst_addr = w_fetch_addr;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;

  // Fetch FSM; a redirect overrides every other event in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_req_pc   <= 64'd0;
      r_drop     <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_pc    <= 64'd0;
      r_if_inst  <= NOP;
    end else if (br_e) begin
      r_pc       <= w_br_tgt;
      r_if_valid <= 1'b0;
      case (r_state)
        S_REQ: begin
          if (inst_gnt) begin
            // The just-granted fetch is for the old path; its response must be dropped.
            r_req_pc <= w_fetch_addr;
            r_drop   <= 1'b1;
            r_state  <= S_WAIT;
          end else begin
            r_state  <= S_REQ;
          end
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            r_drop  <= 1'b0;
            r_state <= S_REQ;
          end else begin
            r_drop  <= 1'b1;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (inst_gnt) begin
            r_req_pc <= w_fetch_addr;
            r_pc     <= w_fetch_addr + 64'd4;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (inst_rvalid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_req_pc;
              r_if_inst  <= inst_rdata;
              r_state    <= S_FULL;
            end
          end
        end
        S_FULL: begin
          // Next fetch only starts once decode has taken the held instruction.
          if (!stall) begin
            r_if_valid <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_pcgen.sv
// Directed bench for ifu_pcgen: straight-line fetch, stall, redirects, wrap.
module tb_ifu_pcgen;

  logic        clk = 1'b0;
  logic        resetn;
  logic        br_e;
  logic [63:0] br_addr;
  logic        stall;
  logic        inst_req;
  logic [63:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  // Second instance with a reset PC at the top of the address space.
  logic        w_br_e    = 1'b0;
  logic [63:0] w_br_addr = 64'd0;
  logic        w_stall   = 1'b0;
  logic        w_gnt     = 1'b1;
  logic        w_rvalid  = 1'b1;
  logic [31:0] w_rdata   = 32'h1234_5678;
  logic        w_req;
  logic [63:0] w_addr;
  logic        w_ifv;
  logic [63:0] w_ifpc;
  logic [31:0] w_ifinst;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifu_pcgen dut (
    .clk(clk), .resetn(resetn), .br_e(br_e), .br_addr(br_addr), .stall(stall),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  ifu_pcgen #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
    .clk(clk), .resetn(resetn), .br_e(w_br_e), .br_addr(w_br_addr), .stall(w_stall),
    .inst_req(w_req), .inst_addr(w_addr), .inst_gnt(w_gnt),
    .inst_rvalid(w_rvalid), .inst_rdata(w_rdata),
    .if_valid(w_ifv), .if_pc(w_ifpc), .if_inst(w_ifinst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after this take effect at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; br_e = 1'b0; br_addr = 64'd0; stall = 1'b0;
    inst_gnt = 1'b0; inst_rvalid = 1'b0; inst_rdata = 32'd0;
    #12;
    chk("rst_req",    {63'd0, inst_req}, 64'd0);
    chk("rst_addr",   inst_addr, 64'h8000_0000);
    chk("rst_valid",  {63'd0, if_valid}, 64'd0);
    chk("rst_pc",     if_pc, 64'd0);
    chk("rst_inst",   {32'd0, if_inst}, 64'h13);
    @(negedge clk); resetn = 1'b1;

    // Straight line
    step();                                   // cycle 1: REQ
    chk("c1_req",  {63'd0, inst_req}, 64'd1);
    chk("c1_addr", inst_addr, 64'h8000_0000);
    chk("wrap_a0", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    inst_gnt = 1'b1;
    step();                                   // WAIT
    chk("c2_req",  {63'd0, inst_req}, 64'd0);
    inst_gnt = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hA000_0000;
    step();                                   // FULL
    chk("c3_valid", {63'd0, if_valid}, 64'd1);
    chk("c3_pc",    if_pc, 64'h8000_0000);
    chk("c3_inst",  {32'd0, if_inst}, 64'hA000_0000);
    inst_rvalid = 1'b0;
    step();                                   // REQ
    chk("c4_valid", {63'd0, if_valid}, 64'd0);
    chk("c4_req",   {63'd0, inst_req}, 64'd1);
    chk("c4_addr",  inst_addr, 64'h8000_0004);
    chk("wrap_a1",  w_addr, 64'd0);
    chk("wrap_req", {63'd0, w_req}, 64'd1);
    inst_gnt = 1'b1;
    step();
    inst_gnt = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hA000_0001;
    step();                                   // FULL
    chk("c6_pc",   if_pc, 64'h8000_0004);
    chk("c6_inst", {32'd0, if_inst}, 64'hA000_0001);
    inst_rvalid = 1'b0;

    // Stall hold for 5 cycles
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stl_valid", {63'd0, if_valid}, 64'd1);
      chk("stl_pc",    if_pc, 64'h8000_0004);
      chk("stl_req",   {63'd0, inst_req}, 64'd0);
    end
    stall = 1'b0;
    step();
    chk("stl_rel_req",  {63'd0, inst_req}, 64'd1);
    chk("stl_rel_addr", inst_addr, 64'h8000_0008);

    // Redirect while waiting
    inst_gnt = 1'b1;
    step();                                   // WAIT
    inst_gnt = 1'b0; br_e = 1'b1; br_addr = 64'h8000_0103;
    step();                                   // WAIT, drop=1
    chk("rw_req",   {63'd0, inst_req}, 64'd0);
    chk("rw_valid", {63'd0, if_valid}, 64'd0);
    br_e = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hDEAD_BEEF;
    step();                                   // REQ
    chk("rw_inst",  {32'd0, if_inst}, 64'hA000_0001);
    chk("rw_valid2",{63'd0, if_valid}, 64'd0);
    chk("rw_req2",  {63'd0, inst_req}, 64'd1);
    chk("rw_addr",  inst_addr, 64'h8000_0100);
    inst_rvalid = 1'b0;

    // Redirect coincident with grant
    inst_gnt = 1'b1; br_e = 1'b1; br_addr = 64'h8000_0200;
    step();                                   // WAIT, drop=1
    chk("rg_req", {63'd0, inst_req}, 64'd0);
    inst_gnt = 1'b0; br_e = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hBAD0_0001;
    step();                                   // REQ
    chk("rg_valid", {63'd0, if_valid}, 64'd0);
    chk("rg_req2",  {63'd0, inst_req}, 64'd1);
    chk("rg_addr",  inst_addr, 64'h8000_0200);
    inst_rvalid = 1'b0; inst_gnt = 1'b1;
    step();
    inst_gnt = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hC000_0000;
    step();                                   // FULL
    chk("rg_pc",   if_pc, 64'h8000_0200);
    chk("rg_inst", {32'd0, if_inst}, 64'hC000_0000);
    inst_rvalid = 1'b0;

    // Redirect in FULL while stalled
    stall = 1'b1; br_e = 1'b1; br_addr = 64'h8000_0300;
    step();
    chk("rf_valid", {63'd0, if_valid}, 64'd0);
    chk("rf_req",   {63'd0, inst_req}, 64'd1);
    chk("rf_addr",  inst_addr, 64'h8000_0300);
    stall = 1'b0; br_e = 1'b0;

    // Back-to-back redirects while drop is set
    inst_gnt = 1'b1;
    step();                                   // WAIT on 0x300
    inst_gnt = 1'b0; br_e = 1'b1; br_addr = 64'h100;
    step();
    br_addr = 64'h200;
    step();
    chk("bb_req", {63'd0, inst_req}, 64'd0);
    br_e = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hBAD0_0002;
    step();
    chk("bb_req2",  {63'd0, inst_req}, 64'd1);
    chk("bb_addr",  inst_addr, 64'h200);
    chk("bb_valid", {63'd0, if_valid}, 64'd0);
    inst_rvalid = 1'b0; inst_gnt = 1'b1;
    step();
    inst_gnt = 1'b0; inst_rvalid = 1'b1; inst_rdata = 32'hC000_0001;
    step();
    chk("bb_pc",   if_pc, 64'h200);
    chk("bb_inst", {32'd0, if_inst}, 64'hC000_0001);
    inst_rvalid = 1'b0;

    // Mid-operation reset, with a stray response right after release
    #2 resetn = 1'b0;
    #1;
    chk("mr_valid", {63'd0, if_valid}, 64'd0);
    chk("mr_inst",  {32'd0, if_inst}, 64'h13);
    chk("mr_addr",  inst_addr, 64'h8000_0000);
    chk("mr_req",   {63'd0, inst_req}, 64'd0);
    @(negedge clk); resetn = 1'b1; inst_rvalid = 1'b1; inst_rdata = 32'hBAD0_0003;
    step();                                   // REQ, response ignored
    chk("mr_req2",   {63'd0, inst_req}, 64'd1);
    chk("mr_valid2", {63'd0, if_valid}, 64'd0);
    step();                                   // still REQ, no grant
    chk("mr_valid3", {63'd0, if_valid}, 64'd0);
    chk("mr_addr2",  inst_addr, 64'h8000_0000);
    inst_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifu_pcgen.md
# ifu_pcgen

Instruction-fetch PC generator and fetch controller, the fetch-side receiver of the branch/jump redirect produced by the execute-stage branch unit. It holds the architectural fetch PC, issues single-outstanding instruction requests to instruction memory, and presents fetched instructions to decode through a one-entry output register. It honours decode back-pressure and kills stale fetches on redirect. RV64I without compressed instructions: all fetch addresses are word aligned.

## Interface
Parameters:
- RESET_PC, 64'h0000_0000_8000_0000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- br_e  in  1  redirect request from the execute stage, one-cycle qualifier.
- br_addr  in  64  redirect target, valid when br_e=1.
- stall  in  1  decode cannot accept the instruction held in the output register.
- inst_req  out  1  instruction request valid.
- inst_addr  out  64  request address, {pc[63:2],2'b00}.
- inst_gnt  in  1  memory accepted the request this cycle.
- inst_rvalid  in  1  response valid; earliest one cycle after gnt.
- inst_rdata  in  32  instruction word.
- if_valid  out  1  output register holds a valid instruction.
- if_pc  out  64  PC of the held instruction.
- if_inst  out  32  held instruction.

## Operation
- Registers:
  - pc (next fetch address)
  - req_pc (address of the outstanding request)
  - drop flag
  - 2-bit state
  - output register (if_valid/if_pc/if_inst)
- States:
  - IDLE: after reset only; no request. Next state REQ.
  - REQ: inst_req=1, inst_addr from pc. On gnt: req_pc<=inst_addr, pc<=pc+4, go WAIT.
  - WAIT: awaiting rvalid. On rvalid with drop=0: load output register (if_valid<=1, if_pc<=req_pc, if_inst<=inst_rdata), go FULL. On rvalid with drop=1: discard data, clear drop, go REQ.
  - FULL: output register occupied. If stall=0: if_valid<=0, go REQ. If stall=1: hold everything.
- At most one request outstanding. A new request is issued only after the output register has been consumed, so a response never finds the register occupied.
- Redirect (br_e=1) has priority over all other events in the same cycle:
  - pc<=({br_addr[63:2],2'b00}); if_valid<=0 (held instruction killed regardless of stall).
  - IDLE, FULL, REQ without gnt: go REQ; next cycle inst_addr is the target.
  - REQ with gnt: the granted request is stale. Go WAIT with drop<=1; pc is not incremented.
  - WAIT without rvalid: drop<=1, stay WAIT.
  - WAIT with rvalid: discard response, drop<=0, go REQ.
  - Repeated br_e while drop=1: pc updated to the newest target; drop stays 1.
- br_addr[1:0] are ignored. Misalignment is the branch unit's responsibility.
- pc arithmetic is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, req_pc=0, drop=0
  - inst_req=0, inst_addr=RESET_PC
  - if_valid=0, if_pc=0, if_inst=32'h0000_0013 (nop)
- First inst_req=1 appears in the first cycle after resetn deasserts.
- inst_req, inst_addr and if_* are registered or state-decoded; no combinational path from br_e, stall, gnt or rvalid to any output.
- Best-case latency: REQ+gnt at cycle N, rvalid at N+1, if_valid=1 at N+2.
- Best-case throughput: one instruction per 3 cycles (REQ, WAIT, FULL).
- Redirect at cycle N: if_valid=0 at N+1. A request to the target is issued at N+1, or one cycle after the stale response returns.
- resetn asserted mid-operation: immediate return to reset values. Any response arriving after reset is ignored until a request has been granted.

## Test plan
- Reset/straight line: release reset with gnt=1 and rvalid one cycle later. Required: inst_addr 0x8000_0000, then 0x8000_0004, then 0x8000_0008. if_pc/if_inst match each response, with if_valid pulsing every 3 cycles.
- Stall hold: assert stall for 5 cycles while FULL. Required: if_* stable and inst_req=0 throughout; next request 0x…+4 issued one cycle after stall falls.
- Redirect in WAIT: br_e=1, br_addr=0x8000_0103 while waiting. Required: the late response (rdata 0xDEADBEEF) never appears on if_inst. The next request address is 0x8000_0100.
- Redirect coincident with gnt: required behaviour is drop=1, pc not incremented; the stale response is discarded and the next request goes to the target.
- Redirect in FULL with stall=1: required if_valid=0 next cycle and a request to the target one cycle later.
- Back-to-back redirects: br_e to 0x100 then 0x200 while drop=1. Required: only 0x200 is fetched.
- Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC. Required: the second request address is 0.
